input_buffer_sched: RTL and testbench

//  Sequencer for the ping-pong 64->96-bit input buffer. Gates AXI-Stream writes into the fill bank,

---
 rtl/input_buffer_sched_pkg.sv | 20 ++
 rtl/input_buffer_sched_tile_beat_checker.sv | 36 +++
 rtl/input_buffer_sched.sv | 184 ++++++++++++++++++
 tb/tb_input_buffer_sched.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_buffer_sched_pkg.sv
// Shared constants and FSM encoding for the input buffer sequencer.
package input_buffer_sched_pkg;

  // Two 64-bit beats carry 128 bits and three carry 192 bits = two 96-bit rows.
  localparam int unsigned BEATS_PER_ROW_PAIR = 3;
  // Minimum cycles between the tlast beat and the bank swap (buffer write is registered).
  localparam int unsigned SWAP_GUARD = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_SWAP    = 3'd2,
    ST_STREAM  = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_DONE    = 3'd5,
    ST_ABORT_A = 3'd6,
    ST_ABORT_B = 3'd7
  } sched_state_e;

endpackage

// File: rtl/input_buffer_sched_tile_beat_checker.sv
// Counts accepted beats of the tile being loaded and pulses err when tlast
// arrives early or the expected final beat is not marked tlast.
module input_buffer_sched_tile_beat_checker #(
  parameter int unsigned BEAT_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              beat,
  input  logic              last,
  input  logic [BEAT_W-1:0] exp_beats,
  output logic              err
);

  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_W-1:0] beat_num;

  assign beat_num = beat_cnt + BEAT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      err      <= 1'b0;
    end else if (clr) begin
      beat_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (beat) begin
        beat_cnt <= last ? '0 : beat_num;
        err      <= last ? (beat_num != exp_beats) : (beat_num >= exp_beats);
      end
    end
  end

endmodule

// File: rtl/input_buffer_sched.sv
// Job sequencer for the ping-pong input buffer: gates DMA writes into the fill bank,
// swaps banks once a tile is loaded and streams each tile to the systolic array.
module input_buffer_sched
  import input_buffer_sched_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned TILE_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [DEPTH_LOG2:0]   i_cfg_rows,
  input  logic [TILE_W-1:0]     i_cfg_tiles,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  o_s_tready,
  output logic                  o_bank_swap,
  output logic                  o_rd_en,
  input  logic                  i_core_ready,
  output logic                  o_vec_valid,
  output logic                  o_vec_last,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int unsigned ROWS_W   = DEPTH_LOG2 + 1;
  localparam int unsigned BEAT_W   = DEPTH_LOG2 + 2;
  localparam int unsigned MAX_ROWS = 1 << DEPTH_LOG2;
  localparam int unsigned GUARD_W  = $clog2(SWAP_GUARD + 1);

  sched_state_e        state;
  logic [ROWS_W-1:0]   cfg_rows;
  logic [TILE_W-1:0]   cfg_tiles;
  logic [BEAT_W-1:0]   exp_beats;
  logic                wr_full;
  logic                rd_pend;
  logic [TILE_W-1:0]   tiles_loaded;
  logic [TILE_W-1:0]   tiles_streamed;
  logic [ROWS_W-1:0]   rd_cnt;
  logic [GUARD_W-1:0]  guard_cnt;

  logic aborting;
  logic abort_req;
  logic start_acc;
  logic cfg_ok;
  logic beat;
  logic tlast_beat;
  logic rd_last;
  logic chk_clr;
  logic chk_err;

  // Status decoded straight from the state register.
  assign aborting    = (state == ST_ABORT_A) || (state == ST_ABORT_B);
  assign o_busy      = (state != ST_IDLE) && (state != ST_DONE);
  assign o_done      = (state == ST_DONE);
  assign o_bank_swap = (state == ST_SWAP) || aborting;

  // Write gate: a loaded tile blocks further beats until its bank is swapped out.
  assign o_s_tready = o_busy && !wr_full && (tiles_loaded < cfg_tiles) && !aborting;
  assign beat       = s_tvalid && o_s_tready;
  assign tlast_beat = beat && s_tlast;

  assign o_rd_en = (state == ST_STREAM) && i_core_ready && (rd_cnt < cfg_rows);
  assign rd_last = o_rd_en && (rd_cnt == cfg_rows - ROWS_W'(1));

  assign abort_req = i_abort && o_busy && !aborting;
  assign start_acc = (state == ST_IDLE) && i_start && !i_abort;
  assign cfg_ok    = (i_cfg_rows != '0) && !i_cfg_rows[0] &&
                     (i_cfg_rows <= ROWS_W'(MAX_ROWS)) && (i_cfg_tiles != '0);
  assign chk_clr   = start_acc || (state == ST_ABORT_B);

  input_buffer_sched_tile_beat_checker #(
    .BEAT_W (BEAT_W)
  ) u_beat_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (chk_clr),
    .beat      (beat),
    .last      (s_tlast),
    .exp_beats (exp_beats),
    .err       (chk_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      cfg_rows       <= '0;
      cfg_tiles      <= '0;
      exp_beats      <= '0;
      wr_full        <= 1'b0;
      rd_pend        <= 1'b0;
      tiles_loaded   <= '0;
      tiles_streamed <= '0;
      rd_cnt         <= '0;
      guard_cnt      <= '0;
      o_vec_valid    <= 1'b0;
      o_vec_last     <= 1'b0;
      o_err          <= 1'b0;
    end else begin
      // RAM read data appears one cycle after the read strobe.
      o_vec_valid <= o_rd_en;
      o_vec_last  <= rd_last;

      if (chk_err) begin
        o_err <= 1'b1;
      end

      if (tlast_beat) begin
        wr_full   <= 1'b1;
        guard_cnt <= GUARD_W'(SWAP_GUARD - 1);
      end else if (guard_cnt != '0) begin
        guard_cnt <= guard_cnt - GUARD_W'(1);
      end

      if (o_rd_en) begin
        rd_cnt <= rd_cnt + ROWS_W'(1);
      end

      if (abort_req) begin
        state <= ST_ABORT_A;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start_acc) begin
              o_err          <= !cfg_ok;
              cfg_rows       <= i_cfg_rows;
              cfg_tiles      <= i_cfg_tiles;
              exp_beats      <= BEAT_W'(BEATS_PER_ROW_PAIR) * BEAT_W'(i_cfg_rows >> 1);
              wr_full        <= 1'b0;
              rd_pend        <= 1'b0;
              tiles_loaded   <= '0;
              tiles_streamed <= '0;
              rd_cnt         <= '0;
              if (cfg_ok) begin
                state <= ST_RUN;
              end
            end
          end
          ST_RUN: begin
            if (wr_full && !rd_pend && (guard_cnt == '0)) begin
              state <= ST_SWAP;
            end
          end
          ST_SWAP: begin
            wr_full      <= 1'b0;
            rd_pend      <= 1'b1;
            tiles_loaded <= tiles_loaded + TILE_W'(1);
            state        <= ST_STREAM;
          end
          ST_STREAM: begin
            if (rd_last) begin
              state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            rd_pend        <= 1'b0;
            tiles_streamed <= tiles_streamed + TILE_W'(1);
            rd_cnt         <= '0;
            state          <= (tiles_streamed + TILE_W'(1) == cfg_tiles) ? ST_DONE : ST_RUN;
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          ST_ABORT_A: begin
            state <= ST_ABORT_B;
          end
          ST_ABORT_B: begin
            // Second swap pulse restores bank parity; drop all job progress.
            wr_full        <= 1'b0;
            rd_pend        <= 1'b0;
            tiles_loaded   <= '0;
            tiles_streamed <= '0;
            rd_cnt         <= '0;
            guard_cnt      <= '0;
            state          <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_input_buffer_sched.sv
// Randomised scoreboard bench for input_buffer_sched: a job-level model queues the
// expected vector stream, a negedge monitor pops and compares it.
module tb_input_buffer_sched;

  localparam int unsigned DEPTH_LOG2 = 8;
  localparam int unsigned TILE_W     = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                i_start;
  logic                i_abort;
  logic [DEPTH_LOG2:0] i_cfg_rows;
  logic [TILE_W-1:0]   i_cfg_tiles;
  logic                s_tvalid;
  logic                s_tlast;
  logic                o_s_tready;
  logic                o_bank_swap;
  logic                o_rd_en;
  logic                i_core_ready;
  logic                o_vec_valid;
  logic                o_vec_last;
  logic                o_busy;
  logic                o_done;
  logic                o_err;

  int checks = 0;
  int failures = 0;
  int vec_cnt = 0;
  int swap_cnt = 0;
  int done_cnt = 0;
  int gap_cnt = 0;
  int overlap_cnt = 0;
  bit prev_valid = 1'b0;
  bit prev_last = 1'b0;
  bit kill = 1'b0;
  bit job_over = 1'b0;
  bit hold_ready = 1'b0;
  bit exp_q[$];

  always #5 clk = ~clk;

  input_buffer_sched #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .TILE_W     (TILE_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_cfg_rows   (i_cfg_rows),
    .i_cfg_tiles  (i_cfg_tiles),
    .s_tvalid     (s_tvalid),
    .s_tlast      (s_tlast),
    .o_s_tready   (o_s_tready),
    .o_bank_swap  (o_bank_swap),
    .o_rd_en      (o_rd_en),
    .i_core_ready (i_core_ready),
    .o_vec_valid  (o_vec_valid),
    .o_vec_last   (o_vec_last),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expected vector per o_vec_valid and checks cycle-level rules.
  always @(negedge clk) begin
    if (o_vec_valid) begin
      vec_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL vec_unexpected actual=valid required=no_vector_pending");
      end else begin
        chk("vec_last", int'(o_vec_last), int'(exp_q.pop_front()));
      end
    end else if (prev_valid && !prev_last) begin
      gap_cnt++;
    end
    prev_valid = o_vec_valid;
    prev_last  = o_vec_last;
    if (o_bank_swap) begin
      swap_cnt++;
      chk("swap_with_beat", int'(s_tvalid & o_s_tready), 0);
    end
    if (o_rd_en) chk("rd_en_without_ready", int'(i_core_ready), 1);
    if (o_done) begin
      done_cnt++;
      chk("done_while_busy", int'(o_busy), 0);
    end
    if (o_rd_en && s_tvalid && o_s_tready) overlap_cnt++;
  end

  function automatic int outs_packed();
    return int'({o_s_tready, o_bank_swap, o_rd_en, o_vec_valid, o_vec_last, o_busy, o_done, o_err});
  endfunction

  task automatic start_pulse(input int rows, input int tiles, input bit with_abort);
    @(posedge clk); #1;
    i_cfg_rows  = (DEPTH_LOG2+1)'(rows);
    i_cfg_tiles = TILE_W'(tiles);
    i_start     = 1'b1;
    i_abort     = with_abort;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_abort = 1'b0;
  endtask

  // Upstream DMA: 3*rows/2 beats per tile (one short on bad_tile), random valid gaps.
  task automatic writer(input int rows, input int tiles, input int bad_tile, input int vprob);
    int n;
    bit acc;
    for (int t = 0; t < tiles && !kill; t++) begin
      n = (rows * 3) / 2 - ((t == bad_tile) ? 1 : 0);
      for (int b = 0; b < n && !kill; b++) begin
        acc = 1'b0;
        while (!acc && !kill) begin
          @(posedge clk); #1;
          s_tvalid = ($urandom_range(99) < vprob);
          s_tlast  = (b == n - 1);
          @(negedge clk);
          acc = s_tvalid && o_s_tready;
        end
      end
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic ready_drv(input int mode);
    while (!job_over) begin
      @(posedge clk); #1;
      if (hold_ready)     i_core_ready = 1'b0;
      else if (mode == 0) i_core_ready = 1'b1;
      else if (mode == 1) i_core_ready = ~i_core_ready;
      else                i_core_ready = 1'($urandom_range(1));
    end
  endtask

  // Model: a job streams tiles*rows vectors, last flag on every rows-th, one swap per tile.
  task automatic push_job(input int rows, input int tiles);
    for (int t = 0; t < tiles; t++)
      for (int v = 0; v < rows; v++)
        exp_q.push_back(v == rows - 1);
  endtask

  task automatic run_job(input int rows, input int tiles, input int bad_tile,
                         input int rmode, input int vprob, input bit exp_err);
    int d0, s0, g0, cyc;
    d0 = done_cnt; s0 = swap_cnt; g0 = gap_cnt;
    push_job(rows, tiles);
    kill = 1'b0; job_over = 1'b0; hold_ready = 1'b0;
    i_core_ready = 1'b1;
    start_pulse(rows, tiles, 1'b0);
    @(negedge clk);
    chk("busy_after_start", int'(o_busy), 1);
    chk("err_cleared_by_start", int'(o_err), 0);
    fork
      writer(rows, tiles, bad_tile, vprob);
      ready_drv(rmode);
      begin
        cyc = 0;
        while (done_cnt == d0 && cyc < 20000) begin
          @(negedge clk);
          cyc++;
        end
        kill = 1'b1;
        job_over = 1'b1;
      end
    join
    chk("job_done_count", done_cnt - d0, 1);
    chk("job_swap_count", swap_cnt - s0, tiles);
    chk("job_vectors_left", exp_q.size(), 0);
    chk("job_err_flag", int'(o_err), int'(exp_err));
    if (rmode == 0) chk("job_stall_gaps", gap_cnt - g0, 0);
    @(negedge clk);
    chk("job_idle_busy", int'(o_busy), 0);
    exp_q.delete();
  endtask

  task automatic bad_cfg(input int rows, input int tiles);
    start_pulse(rows, tiles, 1'b0);
    @(negedge clk);
    chk("badcfg_err", int'(o_err), 1);
    chk("badcfg_busy", int'(o_busy), 0);
    repeat (2) @(negedge clk);
    chk("badcfg_tready", int'(o_s_tready), 0);
  endtask

  task automatic abort_job();
    int d0, s0, v0, cyc;
    d0 = done_cnt; s0 = swap_cnt; v0 = vec_cnt;
    push_job(8, 3);
    kill = 1'b0; job_over = 1'b0; hold_ready = 1'b0;
    i_core_ready = 1'b1;
    start_pulse(8, 3, 1'b0);
    fork
      writer(8, 3, -1, 100);
      ready_drv(0);
      begin
        cyc = 0;
        while (vec_cnt - v0 < 3 && cyc < 2000) begin
          @(negedge clk);
          cyc++;
        end
        chk("abort_reached_stream", int'(vec_cnt - v0 >= 3), 1);
        hold_ready = 1'b1;
        @(posedge clk); #2;
        kill = 1'b1;
        i_abort = 1'b1;
        @(posedge clk); #2;
        i_abort = 1'b0;
        @(negedge clk);
        chk("abort_swap_1", int'(o_bank_swap), 1);
        chk("abort_tready", int'(o_s_tready), 0);
        chk("abort_rd_en", int'(o_rd_en), 0);
        @(negedge clk);
        chk("abort_swap_2", int'(o_bank_swap), 1);
        @(negedge clk);
        chk("abort_swap_end", int'(o_bank_swap), 0);
        chk("abort_busy", int'(o_busy), 0);
        job_over = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_swap_total", swap_cnt - s0, 3);
    exp_q.delete();
  endtask

  task automatic reset_mid_job();
    push_job(8, 2);
    kill = 1'b0; job_over = 1'b0; hold_ready = 1'b0;
    start_pulse(8, 2, 1'b0);
    fork
      writer(8, 2, -1, 90);
      ready_drv(2);
      begin
        repeat (15) @(negedge clk);
        chk("reset_pre_busy", int'(o_busy), 1);
        #1;
        rst_n = 1'b0;
        kill = 1'b1;
        #1;
        chk("reset_async_outputs", outs_packed(), 0);
        @(negedge clk);
        chk("reset_held_outputs", outs_packed(), 0);
        job_over = 1'b1;
      end
    join
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_release_outputs", outs_packed(), 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rows, tiles, bad;
    rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0;
    i_cfg_rows = '0; i_cfg_tiles = '0;
    s_tvalid = 1'b0; s_tlast = 1'b0; i_core_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs_packed(), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_outputs", outs_packed(), 0);

    run_job(4, 1, -1, 0, 100, 1'b0);
    run_job(8, 3, -1, 0, 100, 1'b0);
    chk("overlap_seen", int'(overlap_cnt > 0), 1);
    run_job(8, 1, -1, 1, 100, 1'b0);
    run_job(4, 1, 0, 0, 100, 1'b1);
    run_job(4, 2, -1, 2, 80, 1'b0);
    bad_cfg(3, 1);
    run_job(2, 1, -1, 0, 100, 1'b0);
    bad_cfg(4, 0);
    bad_cfg(0, 2);
    bad_cfg(258, 1);
    run_job(256, 2, -1, 2, 90, 1'b0);

    start_pulse(4, 1, 1'b1);
    @(negedge clk);
    chk("abort_beats_start", int'(o_busy), 0);

    abort_job();
    run_job(4, 1, -1, 0, 100, 1'b0);

    for (int j = 0; j < 10; j++) begin
      rows  = 2 * $urandom_range(1, 8);
      tiles = $urandom_range(1, 4);
      bad   = ($urandom_range(3) == 0) ? $urandom_range(0, tiles - 1) : -1;
      run_job(rows, tiles, bad, $urandom_range(0, 2), $urandom_range(40, 100), bad >= 0);
    end

    reset_mid_job();
    run_job(6, 2, -1, 1, 100, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
